calc_responder: RTL and testbench

CALC_RESPONDER -- requirements
Module: calc_responder

---
 rtl/calc_responder_pkg.sv | 31 +++
 rtl/calc_alu.sv | 39 +++
 rtl/calc_responder.sv | 138 +++++++++++++
 tb/tb_calc_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_responder_pkg.sv
// Shared definitions for the calc_responder block: default sizes, command and
// response encodings, and the queued request record.
package calc_responder_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_QDEPTH    = 4;
  localparam int DATA_W        = 32;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  // cmd stays raw so invalid encodings travel through the queue untouched
  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [1:0]        tag;
  } req_t;

endpackage

// File: rtl/calc_alu.sv
// Shared combinational ALU: add/sub with range checking, logical shifts.
module calc_alu
  import calc_responder_pkg::*;
(
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output resp_e             resp,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum  = {1'b0, data1} + {1'b0, data2};
    resp = RESP_ERR;
    data = '0;
    case (cmd)
      CMD_ADD: if (!sum[DATA_W]) begin
        resp = RESP_OK;
        data = sum[DATA_W-1:0];
      end
      CMD_SUB: if (data2 <= data1) begin
        resp = RESP_OK;
        data = data1 - data2;
      end
      CMD_SHL: begin
        resp = RESP_OK;
        data = data1 << data2[4:0];
      end
      CMD_SHR: begin
        resp = RESP_OK;
        data = data1 >> data2[4:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_responder.sv
// Multi-port two-cycle command capture, per-port request queues, round-robin
// arbitration onto one shared ALU, and a registered response stage.
module calc_responder
  import calc_responder_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int QDEPTH    = DEF_QDEPTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_PORTS-1:0][3:0]          in_cmd,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0][1:0]          in_tag,
  output logic [NUM_PORTS-1:0]               in_busy,
  output logic [NUM_PORTS-1:0][1:0]          out_resp,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]   out_data,
  output logic [NUM_PORTS-1:0][1:0]          out_tag
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic {S_IDLE, S_OP2} cap_state_e;

  req_t [NUM_PORTS-1:0] head;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] gnt_oh;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [PW-1:0]        ptr;
  resp_e                alu_resp;
  logic [DATA_W-1:0]    alu_data;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    cap_state_e        state;
    logic [3:0]        cap_cmd;
    logic [DATA_W-1:0] cap_d1;
    logic [1:0]        cap_tag;
    logic              drop;
    req_t              mem [QDEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, push, pop;

    assign full       = (count == CW'(QDEPTH));
    assign pop        = gnt_oh[p];
    // operand 2 is pushed straight from the bus on the OP2 edge
    assign push       = (state == S_OP2) && !drop && (!full || pop);
    assign in_busy[p] = full;
    assign empty[p]   = (count == '0);
    assign head[p]    = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= S_IDLE;
        cap_cmd <= '0;
        cap_d1  <= '0;
        cap_tag <= '0;
        drop    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (in_cmd[p] != 4'd0) begin
            cap_cmd <= in_cmd[p];
            cap_d1  <= in_data[p];
            cap_tag <= in_tag[p];
            drop    <= full;
            state   <= S_OP2;
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= '{cmd: cap_cmd, d1: cap_d1, d2: in_data[p], tag: cap_tag};
          wr_ptr      <= (int'(wr_ptr) == QDEPTH - 1) ? '0 : wr_ptr + 1'b1;
        end
        if (pop)
          rd_ptr <= (int'(rd_ptr) == QDEPTH - 1) ? '0 : rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Search starts at the pointer so the last-granted port goes to the back.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= NUM_PORTS) c = c - NUM_PORTS;
      if (!gnt_vld && !empty[c]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = PW'(c);
        gnt_oh[c] = 1'b1;
      end
    end
  end

  calc_alu u_alu (
    .cmd   (head[gnt_idx].cmd),
    .data1 (head[gnt_idx].d1),
    .data2 (head[gnt_idx].d2),
    .resp  (alu_resp),
    .data  (alu_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      out_resp <= '0;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      if (gnt_vld)
        ptr <= (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_resp[p] <= gnt_oh[p] ? alu_resp : RESP_NONE;
        out_data[p] <= gnt_oh[p] ? alu_data : '0;
        out_tag[p]  <= gnt_oh[p] ? head[gnt_idx].tag : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_calc_responder.sv
// Directed bench for calc_responder: single-request vector table, all-port
// ordering, reset discard, and a saturating scoreboard run for queue-full drops.
module tb_calc_responder;

  localparam int NP = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NP-1:0][3:0]   in_cmd;
  logic [NP-1:0][31:0]  in_data;
  logic [NP-1:0][1:0]   in_tag;
  logic [NP-1:0]        in_busy;
  logic [NP-1:0][1:0]   out_resp;
  logic [NP-1:0][31:0]  out_data;
  logic [NP-1:0][1:0]   out_tag;

  int n_cmp = 0;
  int n_err = 0;

  calc_responder #(.NUM_PORTS(NP), .QDEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_cmd   (in_cmd),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .in_busy  (in_busy),
    .out_resp (out_resp),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  tag;
    logic [1:0]  er;
    logic [31:0] ed;
  } vec_t;

  vec_t        tv [12];
  logic [35:0] q [NP][$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [NP-1:0][1:0] er;
    int                 drops2;
    int                 ph [NP];
    logic [31:0]        d1s [NP];
    logic [1:0]         tgs [NP];
    logic               acc [NP];
    int                 seq;
    int                 nr;
    logic [35:0]        e;

    in_cmd  = '0;
    in_data = '0;
    in_tag  = '0;

    tv[0]  = '{0, 4'd1, 32'h1,        32'h2,        2'd1, 2'd1, 32'h3};
    tv[1]  = '{1, 4'd1, 32'hFFFFFFFF, 32'h1,        2'd2, 2'd2, 32'h0};
    tv[2]  = '{1, 4'd2, 32'h5,        32'h6,        2'd3, 2'd2, 32'h0};
    tv[3]  = '{1, 4'd5, 32'h1,        32'd31,       2'd0, 2'd1, 32'h80000000};
    tv[4]  = '{3, 4'd9, 32'h1234,     32'h1,        2'd2, 2'd2, 32'h0};
    tv[5]  = '{2, 4'd2, 32'd10,       32'd3,        2'd1, 2'd1, 32'd7};
    tv[6]  = '{0, 4'd6, 32'h80000000, 32'd4,        2'd3, 2'd1, 32'h08000000};
    tv[7]  = '{3, 4'd1, 32'h7FFFFFFF, 32'h80000000, 2'd0, 2'd1, 32'hFFFFFFFF};
    tv[8]  = '{2, 4'd2, 32'd5,        32'd5,        2'd2, 2'd1, 32'h0};
    tv[9]  = '{1, 4'd5, 32'hF0000001, 32'h24,       2'd1, 2'd1, 32'h00000010};
    tv[10] = '{0, 4'd3, 32'h55,       32'h66,       2'd3, 2'd2, 32'h0};
    tv[11] = '{3, 4'd6, 32'hFFFFFFFF, 32'd0,        2'd0, 2'd1, 32'hFFFFFFFF};

    do_reset();
    chk("rst_resp", 64'(out_resp), 64'h0);
    chk("rst_data", 64'(out_data[0]), 64'h0);
    chk("rst_busy", 64'(in_busy), 64'h0);

    // single requests: idle at T+1/T+2, result exactly at T+3, gone at T+4
    for (int i = 0; i < 12; i++) begin
      in_cmd[tv[i].port]  = tv[i].cmd;
      in_data[tv[i].port] = tv[i].d1;
      in_tag[tv[i].port]  = tv[i].tag;
      step();
      chk($sformatf("v%0d_t1", i), 64'(out_resp), 64'h0);
      in_cmd  = '0;
      in_tag  = '0;
      in_data[tv[i].port] = tv[i].d2;
      step();
      chk($sformatf("v%0d_t2", i), 64'(out_resp), 64'h0);
      in_data = '0;
      step();
      er = '0;
      er[tv[i].port] = tv[i].er;
      chk($sformatf("v%0d_resp", i), 64'(out_resp), 64'(er));
      chk($sformatf("v%0d_data", i), 64'(out_data[tv[i].port]), 64'(tv[i].ed));
      chk($sformatf("v%0d_tag", i), 64'(out_tag[tv[i].port]), 64'(tv[i].tag));
      step();
      chk($sformatf("v%0d_t4", i), 64'(out_resp), 64'h0);
    end

    // all ports in the same cycle, pointer fresh from reset
    do_reset();
    for (int p = 0; p < NP; p++) begin
      in_cmd[p]  = 4'd1;
      in_data[p] = 32'(p + 10);
      in_tag[p]  = 2'(p);
    end
    step();
    in_cmd = '0;
    in_tag = '0;
    for (int p = 0; p < NP; p++) in_data[p] = 32'd100;
    step();
    in_data = '0;
    step();
    for (int c = 0; c < NP; c++) begin
      er = '0;
      er[c] = 2'd1;
      chk($sformatf("rr%0d_resp", c), 64'(out_resp), 64'(er));
      chk($sformatf("rr%0d_data", c), 64'(out_data[c]), 64'(c + 110));
      chk($sformatf("rr%0d_tag", c), 64'(out_tag[c]), 64'(c));
      step();
    end
    chk("rr_done", 64'(out_resp), 64'h0);

    // reset during operand-2 cycle: request must vanish
    in_cmd[3] = 4'd1; in_data[3] = 32'd5; in_tag[3] = 2'd2;
    step();
    reset = 1'b1;
    in_cmd = '0; in_data[3] = 32'd6;
    step();
    reset = 1'b0;
    in_data = '0; in_tag = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rstA_c%0d", k), 64'(out_resp), 64'h0);
    end

    // reset while the request sits in the queue / is being granted
    in_cmd[3] = 4'd2; in_data[3] = 32'd9; in_tag[3] = 2'd1;
    step();
    in_cmd = '0; in_data[3] = 32'd4;
    step();
    reset = 1'b1;
    in_data = '0; in_tag = '0;
    step();
    reset = 1'b0;
    chk("rstB_now", 64'(out_resp), 64'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rstB_c%0d", k), 64'(out_resp), 64'h0);
    end

    // saturation run: every port issues back-to-back regardless of busy
    do_reset();
    drops2 = 0;
    seq = 1;
    for (int p = 0; p < NP; p++) ph[p] = 0;
    for (int cyc = 0; cyc < 140; cyc++) begin
      nr = 0;
      for (int p = 0; p < NP; p++) begin
        if (out_resp[p] != 2'd0) begin
          nr++;
          if (q[p].size() == 0) begin
            chk($sformatf("sb_p%0d_extra", p), 64'(out_resp[p]), 64'h0);
          end else begin
            e = q[p].pop_front();
            chk($sformatf("sb_p%0d", p), 64'({out_resp[p], out_data[p], out_tag[p]}), 64'(e));
          end
        end
      end
      chk("sb_one_grant", 64'(nr <= 1), 64'h1);
      for (int p = 0; p < NP; p++) begin
        if (cyc >= 80) begin
          in_cmd[p] = '0; in_data[p] = '0; in_tag[p] = '0;
        end else if (ph[p] == 0) begin
          d1s[p] = 32'(seq);
          tgs[p] = 2'(seq);
          acc[p] = !in_busy[p];
          if (p == 2 && in_busy[p]) drops2++;
          in_cmd[p] = 4'd1; in_data[p] = d1s[p]; in_tag[p] = tgs[p];
          seq++;
          ph[p] = 1;
        end else begin
          in_cmd[p] = 4'd7;
          in_data[p] = 32'(p * 1000);
          in_tag[p] = 2'd0;
          if (acc[p]) q[p].push_back({2'd1, d1s[p] + 32'(p * 1000), tgs[p]});
          ph[p] = 0;
        end
      end
      step();
    end
    chk("sb_p2_busy_seen", 64'(drops2 > 0), 64'h1);
    for (int p = 0; p < NP; p++)
      chk($sformatf("sb_p%0d_left", p), 64'(q[p].size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
